// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit owning hi/lo; optional DIV_ZERO_TRAP_EN.
// Latency: mult done one cycle after E0+WIDTH, div one cycle after E0+WIDTH+1 (trapped div-by-zero: after E0+1).
// No backpressure: starts are sampled only in IDLE/DONE, starts while busy are dropped, done is a single-cycle pulse.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultControl,
  input  logic             DivControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc;      // Booth accumulator / partial remainder
  logic [WIDTH-1:0] q;        // multiplier / dividend magnitude, becomes product low / quotient
  logic             qm1;      // Booth q_-1 bit
  logic [WIDTH-1:0] opb;      // multiplicand, or divisor magnitude
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             bzero;

  logic             can_start;
  logic             start;
  logic             start_div;

  logic [WIDTH:0]   mcand_x;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_m;
  logic [WIDTH-1:0] q_m;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] q_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    // MIN maps to itself, which reads correctly as an unsigned 2^(WIDTH-1)
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign can_start = (state == IDLE) || (state == DONE);
  assign start     = MultControl || DivControl;
  assign start_div = DivControl && !MultControl;   // mult wins a tie

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  // One Booth step and one restoring-division step, computed from the current regs
  always_comb begin
    mcand_x   = {opb[WIDTH-1], opb};
    booth_sum = acc;
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + mcand_x;
      2'b10:   booth_sum = acc - mcand_x;
      default: booth_sum = acc;
    endcase
    acc_m  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    q_m    = {booth_sum[0], q[WIDTH-1:1]};
    rem_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb};
    take   = (rem_sh >= {1'b0, opb});
    acc_d  = take ? diff : rem_sh;
    q_d    = {q[WIDTH-2:0], take};
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          state_nxt = RUN;
`ifdef DIV_ZERO_TRAP_EN
          if (start_div && (b == '0)) state_nxt = DONE;
`endif
        end
      end
      RUN:     if (cnt == CW'(1)) state_nxt = op_div ? FIX : DONE;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

`ifdef DIV_ZERO_TRAP_EN
  logic dz;

  // Remember that the op just accepted was a trapped divide-by-zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  dz <= 1'b0;
    else if (can_start && start) dz <= start_div && (b == '0);
  end

  assign div_zero = done && dz;
`else
  assign div_zero = 1'b0;
`endif

  // Operand capture, iteration and result write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0; q <= '0; qm1 <= 1'b0; opb <= '0; cnt <= '0;
      op_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; bzero <= 1'b0;
      hi <= '0; lo <= '0;
    end else if (can_start) begin
      if (start) begin
        cnt    <= CW'(WIDTH);
        op_div <= start_div;
        acc    <= '0;
        qm1    <= 1'b0;
        if (start_div) begin
          q     <= mag(a);
          opb   <= mag(b);
          neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r <= a[WIDTH-1];
          bzero <= (b == '0);
        end else begin
          q   <= a;
          opb <= b;
        end
      end
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      if (op_div) begin
        acc <= acc_d;
        q   <= q_d;
      end else begin
        acc <= acc_m;
        q   <= q_m;
        qm1 <= q[0];
        if (cnt == CW'(1)) begin
          hi <= acc_m[WIDTH-1:0];
          lo <= q_m;
        end
      end
    end else if (state == FIX) begin
      lo <= bzero ? '1 : (neg_q ? -q : q);
      hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

endmodule
